interp_feeder: RTL
==================

INTERP_FEEDER -- requirements
Module: interp_feeder

Interface
REQ-001 Parameter IW, default 16, input/output sample width in bits, signed two's complement.
REQ-002 Parameter UPFACTOR, default 4, output ticks per input sample; SHALL be >= 2.
REQ-003 Parameter CE_DIV, default 8, i_clk cycles per output tick; SHALL be >= 1.
REQ-004 Parameter DEPTH, default 4, input FIFO entries; SHALL be a power of two >= 2.
REQ-005 i_clk  input  1  clock; all state SHALL update on the rising edge.
REQ-006 i_reset  input  1  synchronous, active-high reset.
REQ-007 i_valid  input  1  upstream sample valid.
REQ-008 i_data  input  IW  upstream sample, signed.
REQ-009 o_ready  output  1  FIFO can accept a sample this cycle.
REQ-010 o_ce  output  1  one-cycle tick to drive the interpolator clock enable.
REQ-011 o_sample  output  IW  held sample presented to the interpolator, signed.
REQ-012 o_phase  output  clog2(UPFACTOR)  current polyphase index, 0..UPFACTOR-1.
REQ-013 o_level  output  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
REQ-014 i_clr_err  input  1  clears o_underflow.
REQ-015 o_underflow  output  1  sticky: a load found the FIFO empty.

Function
REQ-016 Tick counter SHALL count 0..CE_DIV-1 and wrap to 0; o_ce SHALL be high exactly in cycles where the counter equals CE_DIV-1 (registered output, no glitching); CE_DIV=1 gives o_ce constantly high after reset.
REQ-017 o_phase SHALL advance by 1 on every edge where o_ce is high, wrapping UPFACTOR-1 -> 0, and SHALL hold otherwise.
REQ-018 Load event: edge where o_ce is high and o_phase == UPFACTOR-1; o_sample SHALL change only at load events and be stable for UPFACTOR consecutive ticks.
REQ-019 At a load event with o_level > 0, o_sample SHALL take the FIFO head and the entry SHALL be popped.
REQ-020 At a load event with o_level == 0, o_sample SHALL become 0 and o_underflow SHALL set.
REQ-021 Push: edge with i_valid && o_ready writes i_data at the tail; o_ready SHALL equal (o_level < DEPTH), combinationally from registered level.
REQ-022 Push and pop on the same edge SHALL leave o_level unchanged and preserve FIFO order.
REQ-023 Push on the same edge as a load with empty FIFO: underflow applies (no bypass); pushed sample SHALL be stored, o_level becomes 1.
REQ-024 i_valid while o_ready is low SHALL be ignored; no entry overwritten, no error flagged.
REQ-025 Pointers SHALL wrap modulo DEPTH; o_level SHALL never exceed DEPTH or go below 0.
REQ-026 o_underflow SHALL stay set until i_clr_err or i_reset; a new underflow on the same edge as i_clr_err SHALL win (flag set).
REQ-027 Load latency: a sample pushed into an empty FIFO SHALL appear on o_sample the cycle after the next load event.

Reset
REQ-028 While i_reset is high: tick counter 0, o_ce 0, o_phase 0, o_sample 0, FIFO emptied (o_level 0, o_ready 1), o_underflow 0; pushes ignored.
REQ-029 Reset asserted mid-operation SHALL discard FIFO contents and restart tick/phase alignment on the first cycle after release (cycle 0).
REQ-030 After release, first o_ce SHALL occur in cycle CE_DIV-1; first load event in cycle UPFACTOR*CE_DIV-1.

Verification
REQ-031 Defaults, reset released, no input -> o_ce high in cycles 7,15,23,31; o_phase 0,1,2,3 before those ticks; o_sample 0; o_underflow set after cycle-31 edge.
REQ-032 Push 0x1234 in cycle 2, 0x8000 in cycle 3 -> o_sample 0x1234 in cycles 32..63, 0x8000 in cycles 64..95, o_level 2 -> 1 -> 0.
REQ-033 Push 5 samples back-to-back from cycle 0 with i_valid held -> o_ready low after 4th push, 5th sample held off and accepted after the cycle-31 pop; order preserved.
REQ-034 FIFO holding 1 entry, push on cycle 31 (load edge) -> o_level stays 1, head sample output, new sample next at cycle-63 load.
REQ-035 Underflow set, i_clr_err pulsed at cycle 40 -> flag clears; pulsed on a load edge with empty FIFO -> flag remains set.
REQ-036 i_reset pulsed at cycle 50 with 3 entries -> o_level 0, o_sample 0, o_phase 0, next o_ce 8 cycles after release.

Source files
------------

// File: rtl/interp_feeder_if.sv
// Upstream sample handshake into the interpolator feeder.
//
// Handshake: a sample transfers on every rising edge where valid && ready.
// ready depends only on registered occupancy, never on valid, so the source
// may look at ready before deciding to raise valid. While valid is high and
// ready is low, data is simply not taken; the source keeps offering it.
//
// Signals:
//   valid  source -> feeder  sample offered this cycle
//   data   source -> feeder  signed sample, IW bits
//   ready  feeder -> source  FIFO has room this cycle
interface interp_feeder_if #(
  parameter int IW = 16
);
  logic          valid;
  logic [IW-1:0] data;
  logic          ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/interp_feeder.sv
// Interpolator feeder: buffers upstream samples in a small FIFO and presents
// one held sample to a polyphase interpolator. It also produces the
// interpolator clock enable and the polyphase index.
//
// Timing: a tick counter divides i_clk by CE_DIV to give o_ce. Every tick
// advances o_phase. The tick on which o_phase is UPFACTOR-1 is a load event.
// At a load event the FIFO head moves into o_sample. If the FIFO is empty,
// o_sample is loaded with 0 and o_underflow is set.
//
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   up (slave)       valid/data/ready upstream handshake
//   o_ce             one-cycle interpolator clock enable
//   o_sample         held sample, changes only at load events
//   o_phase          polyphase index 0..UPFACTOR-1
//   o_level          FIFO occupancy 0..DEPTH
//   i_clr_err        clears o_underflow (a same-edge underflow wins)
//   o_underflow      sticky empty-at-load flag
module interp_feeder #(
  parameter int IW       = 16,
  parameter int UPFACTOR = 4,
  parameter int CE_DIV   = 8,
  parameter int DEPTH    = 4
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  interp_feeder_if.slave              up,
  output logic                        o_ce,
  output logic signed [IW-1:0]        o_sample,
  output logic [$clog2(UPFACTOR)-1:0] o_phase,
  output logic [$clog2(DEPTH):0]      o_level,
  input  logic                        i_clr_err,
  output logic                        o_underflow
);

  localparam int PW = $clog2(UPFACTOR);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(CE_DIV - 1);
  localparam logic [PW-1:0] PH_MAX   = PW'(UPFACTOR - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [CW-1:0] cnt_q,    cnt_d;
  logic          ce_q,     ce_d;
  logic [PW-1:0] phase_q,  phase_d;
  logic [IW-1:0] sample_q, sample_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q,  level_d;
  logic          uf_q,     uf_d;
  logic [IW-1:0] mem_q [DEPTH];
  logic [IW-1:0] mem_d [DEPTH];

  logic ce;
  logic ready;
  logic push;
  logic load;
  logic pop;

  // The enable is the registered compare of the next count, so it lines up
  // exactly with count == CE_DIV-1 and never glitches. With CE_DIV == 1
  // every cycle out of reset is a tick, and the cycle right after release
  // cannot come from a flop that was held low by reset. That case therefore
  // uses the inverted reset directly.
  assign ce    = (CE_DIV == 1) ? ~i_reset : ce_q;
  assign ready = (level_q < LVL_FULL);
  assign push  = up.valid && ready;
  assign load  = ce && (phase_q == PH_MAX);
  // Occupancy is registered, so a sample pushed on the load edge itself is
  // never bypassed into o_sample.
  assign pop   = load && (level_q != '0);

  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    ce_d  = (cnt_d == CNT_MAX);

    phase_d = phase_q;
    if (ce) begin
      phase_d = (phase_q == PH_MAX) ? '0 : phase_q + 1'b1;
    end

    sample_d = sample_q;
    if (load) begin
      sample_d = pop ? mem_q[rd_ptr_q] : '0;
    end

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = up.data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // A clear is applied first, so a new underflow on the same edge wins.
    uf_d = uf_q;
    if (i_clr_err) begin
      uf_d = 1'b0;
    end
    if (load && !pop) begin
      uf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q    <= '0;
      ce_q     <= 1'b0;
      phase_q  <= '0;
      sample_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      uf_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ce_q     <= ce_d;
      phase_q  <= phase_d;
      sample_q <= sample_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      uf_q     <= uf_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign up.ready    = ready;
  assign o_ce        = ce;
  assign o_sample    = sample_q;
  assign o_phase     = phase_q;
  assign o_level     = level_q;
  assign o_underflow = uf_q;

endmodule
